// File: rtl/vdc_pkg.sv
// Shared types for the VDC VRAM slot scheduler: phase states, slot kinds, default address width.
package vdc_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_FREE,
    ST_REFRESH,
    ST_CHR,
    ST_ATR
  } state_t;

  typedef enum logic [2:0] {
    SLOT_NONE,
    SLOT_REFRESH,
    SLOT_CHR,
    SLOT_ATR,
    SLOT_CPU,
    SLOT_BLK
  } slot_t;

endpackage

// File: rtl/vdc_rr_arb.sv
// Two-requester round-robin grant; the pointer only moves on slots where a grant is consumed.
module vdc_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  input  logic req_cpu,
  input  logic req_blk,
  output logic gnt_cpu,
  output logic gnt_blk
);

  // prefer_blk = 1 means CPU was granted last, so BLK wins a tie
  logic prefer_blk;

  always_comb begin
    gnt_cpu = req_cpu && (!req_blk || !prefer_blk);
    gnt_blk = req_blk && (!req_cpu || prefer_blk);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_blk <= 1'b0;
    end else if (advance) begin
      if (gnt_cpu)      prefer_blk <= 1'b1;
      else if (gnt_blk) prefer_blk <= 1'b0;
    end
  end

endmodule

// File: rtl/vdc_vram_sched.sv
// VRAM slot scheduler: per-line refresh / screen / attribute phases, then CPU and block-copy grants.
// Refresh phase exists only when VDC_REFRESH_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_FREE    | idle slots handed to CPU / block requesters
// ST_REFRESH | drr refresh reads from the rolling refresh row
// ST_CHR     | hd+1 screen fetches from dispAddr
// ST_ATR     | hd+1 attribute fetches from attrAddr
module vdc_vram_sched
  import vdc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              lineStart,
  input  logic              fetchLine,
  input  logic              reg_atr,
  input  logic [7:0]        reg_hd,
  input  logic [3:0]        reg_drr,
  input  logic [ADDR_W-1:0] dispAddr,
  input  logic [ADDR_W-1:0] attrAddr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  input  logic              blk_req,
  input  logic              blk_we,
  input  logic [ADDR_W-1:0] blk_addr,
  output logic              blk_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_we,
  output logic              fetch_strobe,
  output logic              fetch_atr,
  output logic [7:0]        fetch_idx,
  output logic              refresh
);

  state_t            state;
  state_t            start_state;
  slot_t             slot;
  logic [8:0]        cnt;
  logic [7:0]        hd_q;
  logic              atr_q;
  logic              fetch_q;
  logic [ADDR_W-1:0] disp_q;
  logic [ADDR_W-1:0] attr_q;
  logic              gnt_cpu;
  logic              gnt_blk;
  logic              arb_go;

`ifdef VDC_REFRESH_EN
  logic [3:0] drr_q;
  logic [7:0] rcnt;
  logic       refresh_r;
  assign refresh = refresh_r;
`else
  logic unused_drr;
  assign unused_drr = ^reg_drr;
  assign refresh    = 1'b0;
`endif

  assign arb_go = enable && !lineStart && (state == ST_FREE);

  vdc_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .advance (arb_go),
    .req_cpu (cpu_req),
    .req_blk (blk_req),
    .gnt_cpu (gnt_cpu),
    .gnt_blk (gnt_blk)
  );

  always_comb begin
    start_state = fetchLine ? ST_CHR : ST_FREE;
`ifdef VDC_REFRESH_EN
    if (reg_drr != 4'd0) start_state = ST_REFRESH;
`endif
    slot = SLOT_NONE;
    if (enable && !lineStart) begin
      case (state)
        ST_REFRESH: slot = SLOT_REFRESH;
        ST_CHR:     slot = SLOT_CHR;
        ST_ATR:     slot = SLOT_ATR;
        default:    slot = gnt_cpu ? SLOT_CPU : (gnt_blk ? SLOT_BLK : SLOT_NONE);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_FREE;
      cnt          <= '0;
      hd_q         <= '0;
      atr_q        <= 1'b0;
      fetch_q      <= 1'b0;
      disp_q       <= '0;
      attr_q       <= '0;
      cpu_ack      <= 1'b0;
      blk_ack      <= 1'b0;
      ram_addr     <= '0;
      ram_rd       <= 1'b0;
      ram_we       <= 1'b0;
      fetch_strobe <= 1'b0;
      fetch_atr    <= 1'b0;
      fetch_idx    <= '0;
`ifdef VDC_REFRESH_EN
      drr_q        <= '0;
      rcnt         <= '0;
      refresh_r    <= 1'b0;
`endif
    end else begin
      // every strobe is a one-slot pulse; idle and disabled cycles drive zeros
      cpu_ack      <= 1'b0;
      blk_ack      <= 1'b0;
      ram_addr     <= '0;
      ram_rd       <= 1'b0;
      ram_we       <= 1'b0;
      fetch_strobe <= 1'b0;
      fetch_atr    <= 1'b0;
      fetch_idx    <= '0;
`ifdef VDC_REFRESH_EN
      refresh_r    <= 1'b0;
`endif
      if (enable && lineStart) begin
        hd_q    <= reg_hd;
        atr_q   <= reg_atr;
        fetch_q <= fetchLine;
        disp_q  <= dispAddr;
        attr_q  <= attrAddr;
        cnt     <= '0;
        state   <= start_state;
`ifdef VDC_REFRESH_EN
        drr_q   <= reg_drr;
`endif
      end else begin
        case (slot)
`ifdef VDC_REFRESH_EN
          SLOT_REFRESH: begin
            refresh_r <= 1'b1;
            ram_rd    <= 1'b1;
            ram_addr  <= ADDR_W'(rcnt);
            rcnt      <= rcnt + 8'd1;
            if (cnt[3:0] == drr_q - 4'd1) begin
              cnt   <= '0;
              state <= fetch_q ? ST_CHR : ST_FREE;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
`endif
          SLOT_CHR, SLOT_ATR: begin
            ram_rd       <= 1'b1;
            fetch_strobe <= 1'b1;
            fetch_atr    <= (slot == SLOT_ATR);
            fetch_idx    <= cnt[7:0];
            ram_addr     <= ((slot == SLOT_ATR) ? attr_q : disp_q) + ADDR_W'(cnt);
            if (cnt == {1'b0, hd_q}) begin
              cnt   <= '0;
              state <= (slot == SLOT_CHR && atr_q) ? ST_ATR : ST_FREE;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
          SLOT_CPU: begin
            cpu_ack  <= 1'b1;
            ram_addr <= cpu_addr;
            ram_we   <= cpu_we;
            ram_rd   <= !cpu_we;
          end
          SLOT_BLK: begin
            blk_ack  <= 1'b1;
            ram_addr <= blk_addr;
            ram_we   <= blk_we;
            ram_rd   <= !blk_we;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vdc_vram_sched.sv
// Scheduler bench: directed line scenarios plus random traffic, checked against a slot-queue reference model.
module tb_vdc_vram_sched;

`ifdef VDC_REFRESH_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, lineStart, fetchLine, reg_atr;
  logic [7:0]  reg_hd;
  logic [3:0]  reg_drr;
  logic [15:0] dispAddr, attrAddr, cpu_addr, blk_addr;
  logic        cpu_req, cpu_we, blk_req, blk_we;
  logic        cpu_ack, blk_ack, ram_rd, ram_we, fetch_strobe, fetch_atr, refresh;
  logic [15:0] ram_addr;
  logic [7:0]  fetch_idx;

  always #5 clk = ~clk;

  vdc_vram_sched #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .lineStart(lineStart), .fetchLine(fetchLine),
    .reg_atr(reg_atr), .reg_hd(reg_hd), .reg_drr(reg_drr), .dispAddr(dispAddr), .attrAddr(attrAddr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
    .blk_req(blk_req), .blk_we(blk_we), .blk_addr(blk_addr), .blk_ack(blk_ack),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_we(ram_we),
    .fetch_strobe(fetch_strobe), .fetch_atr(fetch_atr), .fetch_idx(fetch_idx), .refresh(refresh)
  );

  // kind: 1 refresh, 2 screen, 3 attribute
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [7:0]  idx;
  } slot_e;

  slot_e       exp_q[$];
  int          rcnt_m = 0;
  bit          prefer_blk_m = 1'b0;
  int          checks = 0, errors = 0, cyc = 0;
  bit          cpu_pend = 0, blk_pend = 0;
  int          cpu_rate = 0, blk_rate = 0;
  logic [15:0] cpu_a = '0, blk_a = '0;
  logic        cpu_w = 1'b0, blk_w = 1'b0;
  int          cpu_issued = 0, blk_issued = 0, cpu_seen = 0, blk_seen = 0;
  string       tag = "init";

  task automatic new_reqs();
    if (!cpu_pend && $urandom_range(99) < cpu_rate) begin
      cpu_pend = 1; cpu_a = 16'($urandom); cpu_w = 1'($urandom); cpu_issued++;
    end
    if (!blk_pend && $urandom_range(99) < blk_rate) begin
      blk_pend = 1; blk_a = 16'($urandom); blk_w = 1'($urandom); blk_issued++;
    end
  endtask

  task automatic tick(input bit en, input bit ls, input bit rst);
    logic        e_ref, e_fs, e_fa, e_rd, e_we, e_ca, e_ba;
    logic [7:0]  e_idx;
    logic [15:0] e_addr;
    logic [30:0] obs, expv;
    slot_e       s;
    bit          g_cpu, g_blk;
    enable = en; lineStart = ls; reset = rst;
    cpu_req = cpu_pend; cpu_addr = cpu_a; cpu_we = cpu_w;
    blk_req = blk_pend; blk_addr = blk_a; blk_we = blk_w;
    @(posedge clk);
    cyc++;
    {e_ref, e_fs, e_fa, e_rd, e_we, e_ca, e_ba} = '0;
    e_idx = '0; e_addr = '0;
    if (rst) begin
      exp_q.delete(); rcnt_m = 0; prefer_blk_m = 0;
    end else if (en) begin
      if (ls) begin
        exp_q.delete();
        if (REF_EN) for (int i = 0; i < int'(reg_drr); i++) exp_q.push_back('{1, 16'h0, 8'h0});
        if (fetchLine) begin
          for (int i = 0; i <= int'(reg_hd); i++) exp_q.push_back('{2, 16'(dispAddr + 16'(i)), 8'(i)});
          if (reg_atr)
            for (int i = 0; i <= int'(reg_hd); i++) exp_q.push_back('{3, 16'(attrAddr + 16'(i)), 8'(i)});
        end
      end else if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        e_rd = 1;
        if (s.kind == 1) begin
          e_ref = 1; e_addr = 16'(rcnt_m); rcnt_m = (rcnt_m + 1) % 256;
        end else begin
          e_fs = 1; e_fa = (s.kind == 3); e_idx = s.idx; e_addr = s.addr;
        end
      end else begin
        g_cpu = cpu_pend && (!blk_pend || !prefer_blk_m);
        g_blk = blk_pend && !g_cpu;
        if (g_cpu) begin
          e_ca = 1; e_addr = cpu_a; e_we = cpu_w; e_rd = !cpu_w; prefer_blk_m = 1;
        end else if (g_blk) begin
          e_ba = 1; e_addr = blk_a; e_we = blk_w; e_rd = !blk_w; prefer_blk_m = 0;
        end
      end
    end
    #1;
    obs  = {refresh, fetch_strobe, fetch_atr, fetch_idx, ram_rd, ram_we, cpu_ack, blk_ack, ram_addr};
    expv = {e_ref, e_fs, e_fa, e_idx, e_rd, e_we, e_ca, e_ba, e_addr};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
    if (cpu_ack === 1'b1) cpu_seen++;
    if (blk_ack === 1'b1) blk_seen++;
    if (e_ca) cpu_pend = 0;
    if (e_ba) blk_pend = 0;
    new_reqs();
  endtask

  task automatic start_line(input int drr, input bit fl, input int hd, input bit atr,
                            input logic [15:0] da, input logic [15:0] aa);
    reg_drr = 4'(drr); fetchLine = fl; reg_hd = 8'(hd); reg_atr = atr;
    dispAddr = da; attrAddr = aa;
    tick(1, 1, 0);
    // scramble so that only the latched copies can produce correct slots
    reg_drr = 4'($urandom); fetchLine = 1'($urandom); reg_hd = 8'($urandom);
    reg_atr = 1'($urandom); dispAddr = 16'($urandom); attrAddr = 16'($urandom);
  endtask

  initial begin
    int d;
    reset = 1; enable = 0; lineStart = 0; fetchLine = 0; reg_atr = 0; reg_hd = 0; reg_drr = 0;
    dispAddr = 0; attrAddr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; blk_req = 0; blk_we = 0; blk_addr = 0;

    tag = "reset";
    repeat (3) tick(1, 0, 1);

    tag = "rr_alternate";
    cpu_rate = 100; blk_rate = 100;
    new_reqs();
    repeat (12) tick(1, 0, 0);

    tag = "line_80x2";
    cpu_rate = 30; blk_rate = 30;
    start_line(5, 1, 79, 1, 16'h0000, 16'h0800);
    repeat (5 + 80 + 80 + 10) tick(1, 0, 0);

    tag = "chr_wrap";
    start_line(0, 1, 3, 0, 16'hFFFE, 16'h1234);
    repeat (10) tick(1, 0, 0);

    tag = "rcnt_walk";
    if (REF_EN) begin
      while (rcnt_m != 254) begin
        d = (254 - rcnt_m + 256) % 256;
        if (d > 15) d = 15;
        start_line(d, 0, 0, 0, 16'h0, 16'h0);
        repeat (d + 1) tick(1, 0, 0);
      end
    end
    tag = "rcnt_wrap";
    start_line(4, 0, 0, 0, 16'h0, 16'h0);
    repeat (8) tick(1, 0, 0);

    tag = "abort_chr10";
    cpu_rate = 100; blk_rate = 0;
    start_line(3, 1, 40, 1, 16'h2000, 16'h3000);
    repeat ((REF_EN ? 3 : 0) + 10) tick(1, 0, 0);
    start_line(3, 1, 5, 0, 16'h4000, 16'h5000);
    repeat (20) tick(1, 0, 0);

    tag = "hd255";
    cpu_rate = 20; blk_rate = 20;
    start_line(2, 1, 255, 0, 16'hFF80, 16'h0);
    repeat (265) tick(1, 0, 0);

    tag = "random";
    cpu_rate = 40; blk_rate = 40;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(49) == 0)
        start_line($urandom_range(7), 1'($urandom), $urandom_range(31), 1'($urandom),
                   16'($urandom), 16'($urandom));
      else
        tick($urandom_range(99) < 85, 0, 0);
    end

    tag = "reset_in_atr";
    repeat (40) tick(1, 0, 0);
    cpu_rate = 0; blk_rate = 0;
    start_line(0, 1, 20, 1, 16'h6000, 16'h7000);
    repeat (21 + 5) tick(1, 0, 0);
    if (!cpu_pend) begin
      cpu_pend = 1; cpu_a = 16'h0BEE; cpu_w = 0; cpu_issued++;
    end
    tick(1, 0, 0);
    tick(1, 0, 1);
    repeat (60) tick(1, 0, 0);

    tag = "drain";
    for (int i = 0; i < 600 && (cpu_pend || blk_pend || exp_q.size() > 0); i++) tick(1, 0, 0);
    checks++;
    assert (cpu_seen == cpu_issued) else begin
      errors++;
      $error("FAIL cpu_ack_count observed=%0d expected=%0d", cpu_seen, cpu_issued);
    end
    checks++;
    assert (blk_seen == blk_issued) else begin
      errors++;
      $error("FAIL blk_ack_count observed=%0d expected=%0d", blk_seen, blk_issued);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vdc_vram_sched.md
VDC_VRAM_SCHED -- requirements
Module: vdc_vram_sched

Interface
REQ-001 Parameter ADDR_W, default 16, VRAM address width; all address ports, sums and wraps are ADDR_W bits.
REQ-002 clk  in  1  system clock; one clock for the whole block.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 enable  in  1  clock enable; one VRAM slot per enabled cycle.
REQ-005 lineStart  in  1  start of scanline; single enabled-cycle pulse.
REQ-006 fetchLine  in  1  current line needs screen fetch; valid when lineStart is high.
REQ-007 reg_atr  in  1  R25[6], attribute fetch enable.
REQ-008 reg_hd  in  8  R1, horizontal displayed minus 1.
REQ-009 reg_drr  in  4  R36[3:0], refresh slots per line.
REQ-010 dispAddr, attrAddr  in  ADDR_W each  line base addresses for screen and attribute fetch.
REQ-011 cpu_req/cpu_we  in  1/1  CPU access request and write flag; cpu_addr  in  ADDR_W; cpu_ack  out  1.
REQ-012 blk_req/blk_we  in  1/1  block copy/fill request and write flag; blk_addr  in  ADDR_W; blk_ack  out  1.
REQ-013 ram_addr  out  ADDR_W; ram_rd  out  1; ram_we  out  1  registered VRAM command.
REQ-014 fetch_strobe  out  1; fetch_atr  out  1; fetch_idx  out  8  screen-fetch slot tag.
REQ-015 refresh  out  1  refresh slot active.

Function
REQ-016 FSM states: FREE, REFRESH, CHR, ATR; all transitions occur only on enabled cycles.
REQ-017 lineStart latches reg_drr, reg_hd, reg_atr, dispAddr, attrAddr and fetchLine, then enters REFRESH (if drr≠0), else CHR (if fetchLine), else FREE.
REQ-018 A lineStart arriving in any state aborts the current phase and restarts per REQ-017; lineStart wins over every request that cycle.
REQ-019 REFRESH issues drr slots: refresh=1, ram_rd=1, ram_addr={0…,rcnt[7:0]}; 8-bit rcnt increments per slot and wraps 255->0; the next state is CHR if fetchLine, else FREE.
REQ-020 CHR issues hd+1 slots (9-bit count, hd=255 gives 256): ram_addr=dispAddr+idx mod 2^ADDR_W, fetch_strobe=1, fetch_atr=0, fetch_idx=idx; the next state is ATR if reg_atr, else FREE.
REQ-021 ATR issues the same hd+1 slots from attrAddr with fetch_atr=1, then enters FREE.
REQ-022 FREE grants one requester per slot; with both requesting, the requester not granted last is granted (round robin); otherwise the sole requester is granted.
REQ-023 A request sampled at enabled cycle N produces ack, ram_addr, ram_we=we and ram_rd=~we at cycle N+1, all for exactly one cycle.
REQ-024 Requesters hold req, addr and we until ack; a req still high after its ack is a new request.
REQ-025 Requests are not acked outside FREE and wait there.
REQ-026 With enable low, all state freezes and every strobe, ack, ram_rd and ram_we is 0.
REQ-027 At most one of refresh, fetch_strobe, cpu_ack, blk_ack is high in any cycle.

Reset
REQ-028 Reset forces state FREE, rcnt=0, round-robin pointer to CPU, and every output to 0.
REQ-029 Reset mid-phase discards all remaining slots; no ack is issued for any pending request.

Configuration
REQ-030 With VDC_REFRESH_EN defined, REFRESH behaves as REQ-019.
REQ-031 Without VDC_REFRESH_EN, REFRESH is never entered, reg_drr is ignored and refresh is tied to 0.

Structure
REQ-032 A shared package vdc_pkg holds the state enum, the slot-type enum (NONE, REFRESH, CHR, ATR, CPU, BLK) and the ADDR_W default.
REQ-033 Sub-module vdc_rr_arb implements the two-requester round-robin grant; the phase FSM stays in the top module.

Verification
REQ-034 drr=5, fetchLine=1, hd=79, atr=1, dispAddr=0x0000, attrAddr=0x0800 -> 5 refresh slots, 80 CHR slots at 0x0000-0x004F, 80 ATR slots at 0x0800-0x084F, then FREE.
REQ-035 cpu_req and blk_req held continuously in FREE -> acks alternate CPU, BLK, CPU, …, and each ack comes 1 cycle after its request is sampled.
REQ-036 dispAddr=0xFFFE, hd=3 -> CHR addresses FFFE, FFFF, 0000, 0001.
REQ-037 rcnt=254 and drr=4 -> refresh addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-038 lineStart injected at CHR slot 10 -> CHR is aborted and REFRESH restarts at the next enabled cycle, with no pending ack lost.
REQ-039 reset asserted during ATR with cpu_req pending -> all outputs 0 the next cycle; cpu_ack is issued only after the next FREE grant.
